regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file. It is the next-generation integer register file for the single-cycle core and the planned dual-issue datapath. It provides:
- configurable width and depth, with N read ports and two write ports;
- an optional hardwired-zero register and optional write-to-read bypass;
- a sequenced software-visible clear that zeroes the array one entry per cycle, used on context switch without asserting global reset.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers, power of two, ≥ 2
- AW, $clog2(NREGS), address width (derived)
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data, combinational
- wr_en0, wr_en1  in  1  write enables, ports 0 and 1
- wr_addr0, wr_addr1  in  AW  write addresses
- wr_data0, wr_data1  in  XLEN  write data
- clr_req  in  1  single-cycle pulse; starts clear sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse after the last entry is cleared

## Operation
- Write ports: on a rising clk with wr_enN=1 and not in CLEAR, the array entry at wr_addrN ← wr_dataN.
- Both ports write the same address: port 1 wins.
- ZERO_REG=1:
  - writes to address 0 are discarded, and excluded from the bypass compare;
  - reads of address 0 return 0.
- Reads: rd_data[k] = array[rd_addr[k]], combinational.
- BYPASS=1 and not in CLEAR: if a write enable is active this cycle with a matching address, rd_data[k] returns that wr_data (port 1 before port 0).
- BYPASS=0: reads show the pre-edge value.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 → CLEAR, sweep counter idx ← 0.
  - CLEAR: each cycle array[idx] ← 0, idx ← idx+1. After idx = NREGS-1 is cleared → DONE.
  - DONE: clr_done=1 for one cycle → IDLE.
- In CLEAR and DONE:
  - external writes are ignored, not queued;
  - clr_req is ignored;
  - reads return array contents, partially cleared during the sweep.
- clr_req and write enables in the same IDLE cycle: the writes are performed, then the sweep begins and overwrites them.
- Counter width is AW. It never wraps within a sweep; the FSM leaves CLEAR on the terminal index.

## Timing
- Reset (asynchronous), taking effect immediately:
  - all entries = 0, FSM = IDLE, idx = 0;
  - clr_busy = 0, clr_done = 0, so every rd_data = 0.
- Reset deasserted mid-sweep: block comes up in IDLE with all zeros; no clr_done pulse.
- Write latency: visible on rd_data in the cycle after the edge, or in the same cycle via bypass.
- Clear timing, with clr_req sampled at edge T:
  - clr_busy = 1 from T through the edge that clears entry NREGS-1, i.e. NREGS cycles, plus the DONE cycle;
  - clr_done = 1 in cycle T+NREGS;
  - IDLE at T+NREGS+1, when writes are accepted again.
- clr_busy is registered from state: high in CLEAR and DONE.
- clr_done is registered: high only in DONE.

## Structure
- Shared package regfile_pkg holds:
  - enum rf_clr_state_t {IDLE, CLEAR, DONE};
  - default localparams for XLEN and NREGS.
- Sub-module regfile_sweep_ctrl contains:
  - inputs clk, reset, clr_req;
  - the FSM and the idx counter;
  - outputs sweep_we, sweep_addr, clr_busy, clr_done.
- The top level holds the array, write arbitration, zero-register masking and the per-port bypass muxes, using a generate loop over NRD.

## Test plan
- Reset, then read all addresses on every port → all 0, clr_busy=0, clr_done=0.
- Write 0xDEADBEEF to x5 via port 0 with rd_addr[0]=5 in the same cycle:
  - BYPASS=1: rd_data[0]=0xDEADBEEF in the same cycle;
  - BYPASS=0: old value that cycle, new value in the next cycle.
- Port 0 writes 0x1111 and port 1 writes 0x2222, both to x7 → x7=0x2222.
- Write 0xFFFFFFFF to x0 with ZERO_REG=1 → x0 reads 0, including in the write cycle.
- Fill x1..x31 with their index, then pulse clr_req:
  - clr_busy high for 33 cycles (NREGS=32);
  - clr_done pulses at T+32;
  - a write to x3 at T+10 is dropped;
  - all entries 0 afterward.
- Assert reset at T+5 of a sweep → immediate all-zero, IDLE, no clr_done; a new write to x9 succeeds one cycle after reset deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Clear sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_clr_state_t;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Clear sweep sequencer: walks idx from 0 to NREGS-1, zeroing one entry per
// cycle, then holds DONE for one cycle. clr_busy and clr_done are registered.
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr,
  output logic          clr_busy,
  output logic          clr_done,
  output rf_clr_state_t state_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_clr_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and sweep counter logic; clr_req only matters in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, counter and status flags; asynchronous reset returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sweep_we   = (state_q == CLEAR);
  assign sweep_addr = idx_q;
  assign clr_busy   = busy_q;
  assign clr_done   = done_q;
  assign state_o    = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports
// (port 1 wins on collision), optional hardwired zero register, optional
// same-cycle write-to-read bypass, and a sequenced clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en0,
  input  logic                wr_en1,
  input  logic [AW-1:0]       wr_addr0,
  input  logic [AW-1:0]       wr_addr1,
  input  logic [XLEN-1:0]     wr_data0,
  input  logic [XLEN-1:0]     wr_data1,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  logic            sweep_we;
  logic [AW-1:0]   sweep_addr;
  rf_clr_state_t   sweep_state;
  logic            write_open;
  logic            we0_eff;
  logic            we1_eff;

  regfile_sweep_ctrl #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .state_o    (sweep_state)
  );

  // External writes are only accepted while the sweeper is idle; writes to
  // x0 are dropped when it is hardwired, which also keeps them out of bypass.
  assign write_open = (sweep_state == IDLE);
  assign we0_eff    = wr_en0 && write_open && !((ZERO_REG != 0) && (wr_addr0 == '0));
  assign we1_eff    = wr_en1 && write_open && !((ZERO_REG != 0) && (wr_addr1 == '0));

  // Next array contents: sweep clear, else port 0 then port 1 so port 1 wins.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (sweep_we) begin
      mem_d[sweep_addr] = '0;
    end else begin
      if (we0_eff) mem_d[wr_addr0] = wr_data0;
      if (we1_eff) mem_d[wr_addr1] = wr_data1;
    end
  end

  // Array storage; asynchronous reset zeroes every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    assign ra = rd_addr[k*AW +: AW];

    // Read mux: array value, overridden by bypass (port 1 before port 0),
    // then forced to zero for the hardwired register.
    always_comb begin
      rv = mem_q[ra];
      if (BYPASS != 0) begin
        if (we0_eff && (wr_addr0 == ra)) rv = wr_data0;
        if (we1_eff && (wr_addr1 == ra)) rv = wr_data1;
      end
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
    end

    assign rd_data[k*XLEN +: XLEN] = rv;
  end

endmodule
